// File: rtl/conv_window_sequencer.sv
// Read-side address sequencer for a 3x3, stride-1, pad-1 convolution window.
// Each output pixel gets one issue cycle carrying nine tap addresses and per-tap enables.
module conv_window_sequencer #(
    parameter int width_b  = 7,
    parameter int height_b = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [width_b-1:0]      img_w_m1,
    input  logic [height_b-1:0]     img_h_m1,
    input  logic [2:0]              pass_m1,
    input  logic                    stall,
    output logic [width_b*9-1:0]    readi_wr,
    output logic [height_b*9-1:0]   readi_hr,
    output logic [8:0]              en_read,
    output logic                    en_bias,
    output logic [2:0]              stepr,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [width_b-1:0]  one_w = 1;
    localparam logic [height_b-1:0] one_h = 1;

    state_t                 state, state_nx;
    logic [width_b-1:0]     x, wm;
    logic [height_b-1:0]    y, hm;
    logic [2:0]             p, pm;
    logic                   issue, last;

    logic [width_b*9-1:0]   wr_d;
    logic [height_b*9-1:0]  hr_d;
    logic [8:0]             en_d;
    logic                   bias_d;
    logic [2:0]             stepr_d;
    logic [width_b-1:0]     col;
    logic [height_b-1:0]    row;
    logic                   col_in, row_in;

    assign issue = (state == RUN) && !stall;
    assign last  = (x == wm) && (y == hm) && (p == pm);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (issue && last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Map geometry is captured once per walk so the inputs may change during RUN.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            wm <= img_w_m1;
            hm <= img_h_m1;
            pm <= pass_m1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
            p <= '0;
        end else if (state == IDLE && start) begin
            x <= '0;
            y <= '0;
            p <= '0;
        end else if (issue) begin
            if (x == wm) begin
                x <= '0;
                if (y == hm) begin
                    y <= '0;
                    p <= p + 3'd1;
                end else begin
                    y <= y + one_h;
                end
            end else begin
                x <= x + one_w;
            end
        end
    end

    // Next values of the registered outputs; a stall holds addresses and pass index.
    always_comb begin
        wr_d    = readi_wr;
        hr_d    = readi_hr;
        en_d    = '0;
        bias_d  = 1'b0;
        stepr_d = stepr;
        col     = '0;
        row     = '0;
        col_in  = 1'b0;
        row_in  = 1'b0;
        if (state != RUN) begin
            wr_d    = '0;
            hr_d    = '0;
            stepr_d = '0;
        end else if (!stall) begin
            stepr_d = p;
            bias_d  = (p == 3'd0);
            for (int k = 0; k < 9; k++) begin
                case (k % 3)
                    0: begin col = x - one_w; col_in = (x != '0); end
                    1: begin col = x;         col_in = 1'b1;      end
                    default: begin col = x + one_w; col_in = (x != wm); end
                endcase
                case (k / 3)
                    0: begin row = y - one_h; row_in = (y != '0); end
                    1: begin row = y;         row_in = 1'b1;      end
                    default: begin row = y + one_h; row_in = (y != hm); end
                endcase
                en_d[8-k] = col_in && row_in;
                wr_d[width_b*(9-k)-1 -: width_b]   = (col_in && row_in) ? col : '0;
                hr_d[height_b*(9-k)-1 -: height_b] = (col_in && row_in) ? row : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readi_wr <= '0;
            readi_hr <= '0;
            en_read  <= '0;
            en_bias  <= 1'b0;
            stepr    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            readi_wr <= wr_d;
            readi_hr <= hr_d;
            en_read  <= en_d;
            en_bias  <= bias_d;
            stepr    <= stepr_d;
            busy     <= (state == RUN);
            done     <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer: a nested-loop window model feeds an
// expected-issue queue that a negedge monitor drains as the DUT issues reads.
module tb_conv_window_sequencer;

    localparam int WB = 7;
    localparam int HB = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic [WB-1:0]     img_w_m1 = '0;
    logic [HB-1:0]     img_h_m1 = '0;
    logic [2:0]        pass_m1 = '0;
    logic [WB*9-1:0]   readi_wr;
    logic [HB*9-1:0]   readi_hr;
    logic [8:0]        en_read;
    logic              en_bias;
    logic [2:0]        stepr;
    logic              busy;
    logic              done;

    conv_window_sequencer #(.width_b(WB), .height_b(HB)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .img_w_m1(img_w_m1), .img_h_m1(img_h_m1), .pass_m1(pass_m1),
        .stall(stall), .readi_wr(readi_wr), .readi_hr(readi_hr),
        .en_read(en_read), .en_bias(en_bias), .stepr(stepr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WB*9-1:0] wr;
        logic [HB*9-1:0] hr;
        logic [8:0]      en;
        logic            bias;
        logic [2:0]      stepr;
        logic            last;
    } item_t;

    item_t exp_q[$];
    item_t obs_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    function automatic logic [WB-1:0] wf(input logic [WB*9-1:0] v, input int k);
        return v[WB*(9-k)-1 -: WB];
    endfunction

    function automatic logic [HB-1:0] hf(input logic [HB*9-1:0] v, input int k);
        return v[HB*(9-k)-1 -: HB];
    endfunction

    // Reference: every output pixel of every pass, taps from plain signed offsets.
    task automatic push_model(input int wm, input int hm, input int pm);
        item_t it;
        for (int p = 0; p <= pm; p++)
            for (int y = 0; y <= hm; y++)
                for (int x = 0; x <= wm; x++) begin
                    it.wr = '0; it.hr = '0; it.en = '0;
                    it.bias  = (p == 0);
                    it.stepr = 3'(p);
                    it.last  = (p == pm) && (y == hm) && (x == wm);
                    for (int k = 0; k < 9; k++) begin
                        int xx, yy;
                        xx = x + (k % 3) - 1;
                        yy = y + (k / 3) - 1;
                        if (xx >= 0 && xx <= wm && yy >= 0 && yy <= hm) begin
                            it.en[8-k] = 1'b1;
                            it.wr[WB*(9-k)-1 -: WB] = WB'(xx);
                            it.hr[HB*(9-k)-1 -: HB] = HB'(yy);
                        end
                    end
                    exp_q.push_back(it);
                end
    endtask

    logic            prev_last = 1'b0;
    logic [WB*9-1:0] hold_wr = '0;
    logic [HB*9-1:0] hold_hr = '0;
    logic [2:0]      hold_stepr = '0;

    always @(negedge clk) begin
        item_t e, o;
        if (!reset_n) begin
            exp_q.delete();
            prev_last = 1'b0;
            hold_wr = '0; hold_hr = '0; hold_stepr = '0;
        end else begin
            chk("done_pulse", done, prev_last);
            if (prev_last) chk("busy_fall", busy, 1'b0);
            prev_last = 1'b0;
            if (busy && en_read != '0) begin
                chk("issue_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("issue", {readi_wr, readi_hr, en_read, en_bias, stepr},
                                 {e.wr, e.hr, e.en, e.bias, e.stepr});
                    prev_last = e.last;
                end
                o.wr = readi_wr; o.hr = readi_hr; o.en = en_read;
                o.bias = en_bias; o.stepr = stepr; o.last = 1'b0;
                obs_q.push_back(o);
                hold_wr = readi_wr; hold_hr = readi_hr; hold_stepr = stepr;
            end else if (busy) begin
                chk("stall_hold", {en_bias, readi_wr, readi_hr, stepr},
                                  {1'b0, hold_wr, hold_hr, hold_stepr});
            end else begin
                chk("idle_outputs", {en_read, en_bias, readi_wr, readi_hr}, '0);
                hold_wr = '0; hold_hr = '0; hold_stepr = '0;
            end
        end
    end

    // mode: 0 no stall, 1 random stall, 2 stall on RUN cycles 2 and 3, 3 extra start mid-run
    task automatic run_job(input int wm, input int hm, input int pm, input int mode);
        int total, iss, last_it, it;
        logic s;
        bit seen;
        total = (wm + 1) * (hm + 1) * (pm + 1);
        obs_q.delete();
        push_model(wm, hm, pm);
        @(posedge clk); #2;
        start = 1'b1;
        img_w_m1 = WB'(wm); img_h_m1 = HB'(hm); pass_m1 = 3'(pm);
        iss = 0; last_it = -1; seen = 0;
        for (it = 1; it <= 4000; it++) begin
            @(posedge clk); #2;
            start = (mode == 3 && it == 3);
            img_w_m1 = WB'($urandom); img_h_m1 = HB'($urandom); pass_m1 = 3'($urandom);
            s = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 2) ? (it == 2 || it == 3) : 1'b0;
            stall = s;
            if (iss < total && !s) begin
                iss++;
                if (iss == total) last_it = it;
            end
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        stall = 1'b0;
        start = 1'b0;
        chk("done_seen", seen, 1'b1);
        chk("done_latency", it, last_it + 2);
        chk("issue_count", obs_q.size(), total);
        chk("queue_drained", exp_q.size(), 0);
        @(posedge clk);
    endtask

    task automatic reset_abort();
        obs_q.delete();
        push_model(3, 2, 0);
        @(posedge clk); #2;
        start = 1'b1; img_w_m1 = 7'd3; img_h_m1 = 3'd2; pass_m1 = 3'd0;
        for (int it = 1; it <= 5; it++) begin
            @(posedge clk); #2;
            start = 1'b0;
        end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("abort_outputs_zero", {readi_wr, readi_hr, en_read, en_bias, stepr, busy, done}, '0);
        chk("issues_before_reset", obs_q.size(), 4);
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("idle_after_abort", {busy, done}, 2'b00);
    endtask

    initial begin
        #900000;
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {readi_wr, readi_hr, en_read, en_bias, stepr, busy, done}, '0);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_job(2, 1, 0, 0);
        chk("en_at_0_0", obs_q[0].en, 9'b000_011_011);
        chk("en_at_1_0", obs_q[1].en, 9'b000_111_111);
        chk("en_at_2_1", obs_q[5].en, 9'b110_110_000);
        for (int i = 0; i < 6; i++) chk("bias_stepr_3x2", {obs_q[i].bias, obs_q[i].stepr}, 4'b1000);

        run_job(7, 3, 0, 0);
        chk("tap0_addr", {wf(obs_q[19].wr, 0), hf(obs_q[19].hr, 0)}, {7'd2, 3'd1});
        chk("tap4_addr", {wf(obs_q[19].wr, 4), hf(obs_q[19].hr, 4)}, {7'd3, 3'd2});
        chk("tap8_addr", {wf(obs_q[19].wr, 8), hf(obs_q[19].hr, 8)}, {7'd4, 3'd3});
        chk("interior_en", obs_q[19].en, 9'h1FF);

        run_job(1, 1, 2, 0);
        for (int i = 0; i < 12; i++)
            chk("multipass_seq", {obs_q[i].stepr, obs_q[i].bias}, {3'(i / 4), (i < 4)});

        run_job(1, 1, 0, 2);
        chk("stall_resume_pos", {wf(obs_q[1].wr, 4), hf(obs_q[1].hr, 4)}, {7'd1, 3'd0});

        run_job(2, 2, 1, 3);
        run_job(0, 0, 0, 0);
        chk("min_walk_en", obs_q[0].en, 9'b000_010_000);

        reset_abort();
        run_job(3, 2, 0, 0);

        for (int j = 0; j < 15; j++)
            run_job($urandom_range(0, 11), $urandom_range(0, 7), $urandom_range(0, 2), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
